joy_db15_responder: RTL

- Device-side end of the DB15 serial joystick link. It emulates the external shift-register adapter that the host-side DB15 reader polls through JOY_LOAD, JOY_CLK and JOY_DATA.
- It parallel-loads two 12-bit player button words and shifts them out one bit per JOY_CLK rising edge.
- Used in the loopback/self-test build and as the bench model for the DB15 reader. Runs on the 48 MHz joystick clock domain.

---
 rtl/joy_db15_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/joy_db15_responder.sv
// joy_db15_responder
// Device-side emulation of the DB15 joystick shift-register adapter.
// Two 12-bit button words are parallel-loaded while JOY_LOAD is low. They are
// then shifted out LSB first, one bit per synchronized JOY_CLK rising edge.
// Optional macro JOY_DB15_GLITCH_FILTER_EN adds a FILTER_LEN-sample agreement
// filter behind each input synchronizer.
module joy_db15_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_clk_in,
  input  logic        joy_load_in,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  output logic        joy_data_out,
  output logic [4:0]  bit_count,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [4:0] FRAME_BITS = 5'd24;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("joy_db15_responder: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_s;
  logic                   load_s;

  // Synchronizer chains. They reset to 1 so that no rising JOY_CLK edge is
  // seen as a result of reset itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      load_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk_in};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load_in};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign load_s = load_sync[SYNC_STAGES-1];

  // clk_lvl/load_lvl are the cleaned levels. clk_prev/load_prev hold the
  // levels of the previous cycle for edge detection.
  logic clk_lvl;
  logic load_lvl;
  logic clk_prev;
  logic load_prev;

`ifdef JOY_DB15_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] load_cnt;

  // The new level is accepted in the same cycle as the FILTER_LEN-th agreeing
  // sample. The edge is therefore acted on without an extra register stage.
  always_comb begin
    clk_lvl  = clk_prev;
    load_lvl = load_prev;
    if (clk_s != clk_prev && clk_cnt == CNT_LAST) clk_lvl = clk_s;
    if (load_s != load_prev && load_cnt == CNT_LAST) load_lvl = load_s;
  end

  // Agreement counters. They restart whenever the sample matches the held
  // level, and also when a change is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev  <= 1'b1;
      load_prev <= 1'b1;
      clk_cnt   <= '0;
      load_cnt  <= '0;
    end else begin
      clk_prev  <= clk_lvl;
      load_prev <= load_lvl;
      if (clk_s == clk_prev || clk_lvl != clk_prev) clk_cnt <= '0;
      else                                          clk_cnt <= clk_cnt + 1'b1;
      if (load_s == load_prev || load_lvl != load_prev) load_cnt <= '0;
      else                                              load_cnt <= load_cnt + 1'b1;
    end
  end
`else
  assign clk_lvl  = clk_s;
  assign load_lvl = load_s;

  // Previous-sample registers for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev  <= 1'b1;
      load_prev <= 1'b1;
    end else begin
      clk_prev  <= clk_lvl;
      load_prev <= load_lvl;
    end
  end
`endif

  logic        clk_rise;
  logic        load_fall;
  logic [23:0] frame;
  logic [23:0] shreg;

  assign clk_rise  = clk_lvl & ~clk_prev;
  assign load_fall = ~load_lvl & load_prev;
  assign frame     = ~{joystick2, joystick1};

  // Load/shift datapath. Load has priority, so a JOY_CLK edge in the same
  // cycle as the load falling edge is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '1;
      bit_count  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_lvl) begin
        shreg     <= frame;
        bit_count <= '0;
        if (load_fall) overrun <= 1'b0;
      end else if (clk_rise) begin
        if (bit_count == FRAME_BITS) begin
          overrun <= 1'b1;
        end else begin
          shreg     <= {1'b1, shreg[23:1]};
          bit_count <= bit_count + 5'd1;
          if (bit_count == FRAME_BITS - 5'd1) frame_done <= 1'b1;
        end
      end
    end
  end

  // Once the frame is exhausted the line idles high (no button pressed).
  always_comb begin
    joy_data_out = shreg[0];
    if (bit_count == FRAME_BITS) joy_data_out = 1'b1;
  end

endmodule
